bcd_scan_display: RTL

- Downstream display stage for the 16-bit load/modulo counter; consumes its count value (DOUT) and terminal-count strobe.
- Converts a binary count to BCD with a serial shift-add-3 (double-dabble) engine.
- Drives a 4-digit multiplexed 7-segment display. Typical hookup: DIN <= counter DOUT, EN <= counter COUT or a periodic refresh strobe.

---
 rtl/bcd_scan_display_pkg.sv | 24 ++
 rtl/bcd_scan_display_if.sv | 24 ++
 rtl/bcd_scan_display_seg7_decode.sv | 32 +++
 rtl/bcd_scan_display.sv | 136 +++++++++++++
 4 files changed

// File: rtl/bcd_scan_display_pkg.sv
// Shared constants for the BCD scan display: FSM state encodings,
// 7-segment patterns ({g,f,e,d,c,b,a}, active high) and the add-3 threshold.
package bcd_scan_display_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_CONV = 1'b1;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // A BCD nibble at or above this value gets +3 before each shift.
    localparam logic [3:0] ADD3_THRESH = 4'd5;

endpackage

// File: rtl/bcd_scan_display_if.sv
// Signal bundle between the count source/display consumer and the BCD scan display.
interface bcd_scan_display_if #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 4
);
    logic                  EN;
    logic [WIDTH-1:0]      DIN;
    logic                  BUSY;
    logic                  DONE;
    logic                  OVF;
    logic [4*DIGITS-1:0]   BCD;
    logic [6:0]            SEG;
    logic [DIGITS-1:0]     SEL;

    modport master (
        output EN, DIN,
        input  BUSY, DONE, OVF, BCD, SEG, SEL
    );

    modport slave (
        input  EN, DIN,
        output BUSY, DONE, OVF, BCD, SEG, SEL
    );
endinterface

// File: rtl/bcd_scan_display_seg7_decode.sv
// Combinational BCD-nibble to 7-segment decoder; overflow forces a dash.
module seg7_decode
    import bcd_scan_display_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       ovf,
    output logic [6:0] seg
);

    // Map one digit to its segment pattern; non-decimal nibbles blank.
    always_comb begin
        seg = SEG_BLANK;
        if (ovf) begin
            seg = SEG_DASH;
        end else begin
            case (nibble)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/bcd_scan_display.sv
// Serial double-dabble binary-to-BCD converter driving a multiplexed
// 7-segment display. The display only ever shows the latched result.
module bcd_scan_display
    import bcd_scan_display_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 1024
) (
    input  logic               CLK,
    input  logic               RST,
    bcd_scan_display_if.slave  bus
);

    localparam int SW     = 4 * (DIGITS + 1);
    localparam int STEP_W = $clog2(WIDTH + 1);
    localparam int PW     = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int IW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [DIGITS-1:0] SEL_ONE = {{(DIGITS-1){1'b0}}, 1'b1};

    logic [0:0]          state_q, state_d;
    logic [WIDTH-1:0]    sreg_q, sreg_d;
    logic [SW-1:0]       scratch_q, scratch_d;
    logic [SW-1:0]       adj;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [4*DIGITS-1:0] bcd_q, bcd_d;
    logic                ovf_q, ovf_d;
    logic                done_q, done_d;

    logic [PW-1:0]       presc_q, presc_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [DIGITS-1:0]   sel_q, sel_d;
    logic [6:0]          seg_q, seg_d;
    logic [3:0]          digit;

    // Conversion FSM: accept in IDLE, then one add-3/shift step per clock.
    always_comb begin
        state_d   = state_q;
        sreg_d    = sreg_q;
        scratch_d = scratch_q;
        step_d    = step_q;
        bcd_d     = bcd_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;
        adj       = scratch_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.EN) begin
                    sreg_d    = bus.DIN;
                    scratch_d = '0;
                    step_d    = '0;
                    state_d   = ST_CONV;
                end
            end
            ST_CONV: begin
                for (int i = 0; i < DIGITS + 1; i++) begin
                    if (scratch_q[4*i +: 4] >= ADD3_THRESH) begin
                        adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
                    end
                end
                {scratch_d, sreg_d} = {adj[SW-2:0], sreg_q, 1'b0};
                step_d = step_q + STEP_W'(1);
                if (step_q == STEP_W'(WIDTH - 1)) begin
                    bcd_d   = scratch_d[4*DIGITS-1:0];
                    ovf_d   = (scratch_d[SW-1 -: 4] != 4'd0);
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control and result registers, cleared by the asynchronous reset.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= ST_IDLE;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bcd_q   <= bcd_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    // Conversion datapath registers; always loaded on accept, so no reset needed.
    always_ff @(posedge CLK) begin
        sreg_q    <= sreg_d;
        scratch_q <= scratch_d;
        step_q    <= step_d;
    end

    // Free-running scan prescaler and digit index; SEL/SEG follow the index.
    always_comb begin
        presc_d = presc_q + PW'(1);
        idx_d   = idx_q;
        if (presc_q == PW'(SCAN_DIV - 1)) begin
            presc_d = '0;
            idx_d   = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
        end
        digit = bcd_q[4*idx_q +: 4];
        sel_d = SEL_ONE << idx_q;
    end

    seg7_decode u_seg7_decode (
        .nibble (digit),
        .ovf    (ovf_q),
        .seg    (seg_d)
    );

    // Scan registers; SEL and SEG update on the same edge.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            presc_q <= '0;
            idx_q   <= '0;
            sel_q   <= SEL_ONE;
            seg_q   <= SEG_0;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            sel_q   <= sel_d;
            seg_q   <= seg_d;
        end
    end

    assign bus.BUSY = (state_q == ST_CONV);
    assign bus.DONE = done_q;
    assign bus.OVF  = ovf_q;
    assign bus.BCD  = bcd_q;
    assign bus.SEL  = sel_q;
    assign bus.SEG  = seg_q;

endmodule
